// File: rtl/sext_arbiter.sv
// rtl/sext_arbiter.sv - two-requester arbiter around a shared 12-to-16 sign-extension datapath
//
// Arbitrates between requester A (decode immediates) and requester B
// (branch/jump offsets), sign-extends the winning 12-bit field into a
// one-entry output register with a valid/ready handshake, and keeps
// saturating per-requester grant counters for debug.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_a, imm_a, gnt_a      requester A: request, 12-bit field, combinational grant
//   req_b, imm_b, gnt_b      requester B: request, 12-bit field, combinational grant
//   out_valid, out_data,     output register: valid flag, 16-bit result,
//   out_owner, out_ready     owner (0 = A, 1 = B), consumer ready
//   cnt_a, cnt_b             saturating grant counters
module sext_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [11:0]      imm_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [11:0]      imm_b,
  output logic             gnt_b,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_owner,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic last_owner;
  logic slot_free;
  logic pick_a;

  // The slot can be refilled in the same cycle the consumer drains it.
  assign slot_free = !out_valid || out_ready;

  // Round-robin: whoever did not win last time wins the next contention.
  assign pick_a = (FIXED_PRIO != 0) ? 1'b1 : last_owner;

  assign gnt_a = req_a && slot_free && !rst && (!req_b || pick_a);
  assign gnt_b = req_b && slot_free && !rst && (!req_a || !pick_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= 16'h0000;
      out_owner  <= 1'b0;
      last_owner <= 1'b1;
      cnt_a      <= '0;
      cnt_b      <= '0;
    end else begin
      if (gnt_a) begin
        out_valid  <= 1'b1;
        out_data   <= {{4{imm_a[11]}}, imm_a};
        out_owner  <= 1'b0;
        last_owner <= 1'b0;
        if (cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      end else if (gnt_b) begin
        out_valid  <= 1'b1;
        out_data   <= {{4{imm_b[11]}}, imm_b};
        out_owner  <= 1'b1;
        last_owner <= 1'b1;
        if (cnt_b != '1) cnt_b <= cnt_b + 1'b1;
      end else if (out_ready) begin
        // Drained with nothing new: data and owner keep their last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sext_arbiter.sv
// tb/tb_sext_arbiter.sv - scoreboard bench for sext_arbiter
module tb_sext_arbiter;

  logic        clk;
  logic        rst;
  logic        req_a, req_b, out_ready;
  logic [11:0] imm_a, imm_b;

  logic        gnt_a, gnt_b, out_valid, out_owner;
  logic [15:0] out_data;
  logic [7:0]  cnt_a, cnt_b;

  logic        fp_gnt_a, fp_gnt_b, fp_out_valid, fp_out_owner;
  logic [15:0] fp_out_data;
  logic [7:0]  fp_cnt_a, fp_cnt_b;

  logic        c2_gnt_a, c2_gnt_b, c2_out_valid, c2_out_owner;
  logic [15:0] c2_out_data;
  logic [1:0]  c2_cnt_a, c2_cnt_b;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb_q[$];

  sext_arbiter #(.FIXED_PRIO(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .imm_a(imm_a), .gnt_a(gnt_a),
    .req_b(req_b), .imm_b(imm_b), .gnt_b(gnt_b),
    .out_valid(out_valid), .out_data(out_data), .out_owner(out_owner),
    .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  sext_arbiter #(.FIXED_PRIO(1), .CNT_W(8)) dut_fp (
    .clk(clk), .rst(rst),
    .req_a(req_a), .imm_a(imm_a), .gnt_a(fp_gnt_a),
    .req_b(req_b), .imm_b(imm_b), .gnt_b(fp_gnt_b),
    .out_valid(fp_out_valid), .out_data(fp_out_data), .out_owner(fp_out_owner),
    .out_ready(out_ready), .cnt_a(fp_cnt_a), .cnt_b(fp_cnt_b)
  );

  sext_arbiter #(.FIXED_PRIO(0), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .imm_a(imm_a), .gnt_a(c2_gnt_a),
    .req_b(req_b), .imm_b(imm_b), .gnt_b(c2_gnt_b),
    .out_valid(c2_out_valid), .out_data(c2_out_data), .out_owner(c2_out_owner),
    .out_ready(out_ready), .cnt_a(c2_cnt_a), .cnt_b(c2_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every value the consumer takes must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got data %0h owner %0b expected nothing", out_data, out_owner);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        chk("sb_data", {16'h0, out_data}, {16'h0, e[15:0]});
        chk("sb_owner", {31'h0, out_owner}, {31'h0, e[16]});
      end
    end
  end

  // One clock cycle: drive inputs, record the expected grant, check grants
  // mid-cycle, then step past the rising edge.
  task automatic cyc(input logic r, input logic ra, input logic [11:0] ia,
                     input logic rb, input logic [11:0] ib, input logic rdy,
                     input logic ega, input logic egb, input logic [15:0] exp_d);
    rst = r; req_a = ra; imm_a = ia; req_b = rb; imm_b = ib; out_ready = rdy;
    if (r) sb_q.delete();
    if (ega) sb_q.push_back({1'b0, exp_d});
    if (egb) sb_q.push_back({1'b1, exp_d});
    @(negedge clk);
    chk("gnt_a", {31'h0, gnt_a}, {31'h0, ega});
    chk("gnt_b", {31'h0, gnt_b}, {31'h0, egb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; imm_a = '0; imm_b = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 16'h0000);

    // Reset state
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", {16'h0, out_data}, 32'h0);
    chk("rst_owner", {31'h0, out_owner}, 32'h0);
    chk("rst_cnt_a", {24'h0, cnt_a}, 32'h0);
    chk("rst_cnt_b", {24'h0, cnt_b}, 32'h0);

    // Lone requests and sign extension
    cyc(0, 1, 12'h800, 0, 12'h000, 1, 1, 0, 16'hF800);
    chk("lat_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_data", {16'h0, out_data}, 32'h0000F800);
    chk("lat_cnt_a", {24'h0, cnt_a}, 32'h1);
    cyc(0, 0, 12'h000, 1, 12'h7FF, 1, 0, 1, 16'h07FF);
    cyc(0, 0, 12'h000, 1, 12'hFFF, 1, 0, 1, 16'hFFFF);
    cyc(0, 0, 12'h000, 1, 12'h000, 1, 0, 1, 16'h0000);
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);
    chk("drain_valid", {31'h0, out_valid}, 32'h0);
    chk("drain_owner", {31'h0, out_owner}, 32'h1);
    chk("p1_cnt_b", {24'h0, cnt_b}, 32'h3);

    // Contention: round-robin on dut, fixed priority on dut_fp
    cyc(1, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 12'h123, 1, 12'h9AB, 1, 1, 0, 16'h0123);
      chk("rr_owner_a", {31'h0, out_owner}, 32'h0);
      cyc(0, 1, 12'h123, 1, 12'h9AB, 1, 0, 1, 16'hF9AB);
      chk("rr_owner_b", {31'h0, out_owner}, 32'h1);
    end
    chk("rr_cnt_a", {24'h0, cnt_a}, 32'h3);
    chk("rr_cnt_b", {24'h0, cnt_b}, 32'h3);
    chk("fp_cnt_a", {24'h0, fp_cnt_a}, 32'h6);
    chk("fp_cnt_b", {24'h0, fp_cnt_b}, 32'h0);
    chk("fp_owner", {31'h0, fp_out_owner}, 32'h0);
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);

    // Counter saturation with CNT_W=2
    cyc(1, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);
    cyc(0, 1, 12'h001, 0, 12'h000, 1, 1, 0, 16'h0001);
    cyc(0, 1, 12'h002, 0, 12'h000, 1, 1, 0, 16'h0002);
    cyc(0, 1, 12'h003, 0, 12'h000, 1, 1, 0, 16'h0003);
    chk("c2_cnt_3", {30'h0, c2_cnt_a}, 32'h3);
    cyc(0, 1, 12'hC00, 0, 12'h000, 1, 1, 0, 16'hFC00);
    cyc(0, 1, 12'h3FF, 0, 12'h000, 1, 1, 0, 16'h03FF);
    chk("c2_cnt_sat", {30'h0, c2_cnt_a}, 32'h3);
    chk("main_cnt_5", {24'h0, cnt_a}, 32'h5);

    // Backpressure
    cyc(0, 1, 12'hABC, 0, 12'h000, 1, 1, 0, 16'hFABC);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 12'h000, 1, 12'h055, 0, 0, 0, 16'h0000);
      chk("stall_data", {16'h0, out_data}, 32'h0000FABC);
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
    end
    cyc(0, 0, 12'h000, 1, 12'h055, 1, 0, 1, 16'h0055);
    chk("nobubble_valid", {31'h0, out_valid}, 32'h1);
    chk("nobubble_data", {16'h0, out_data}, 32'h00000055);
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);

    // Reset with a pending output and both requests high
    cyc(0, 1, 12'h456, 0, 12'h000, 1, 1, 0, 16'h0456);
    cyc(1, 1, 12'h111, 1, 12'h222, 0, 0, 0, 16'h0000);
    chk("rst2_valid", {31'h0, out_valid}, 32'h0);
    chk("rst2_data", {16'h0, out_data}, 32'h0);
    chk("rst2_cnt_a", {24'h0, cnt_a}, 32'h0);
    chk("rst2_cnt_b", {24'h0, cnt_b}, 32'h0);
    cyc(0, 1, 12'h111, 1, 12'h222, 1, 1, 0, 16'h0111);
    cyc(0, 0, 12'h000, 1, 12'h222, 1, 0, 1, 16'h0222);
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 16'h0000);
    chk("end_cnt_a", {24'h0, cnt_a}, 32'h1);
    chk("end_cnt_b", {24'h0, cnt_b}, 32'h1);
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
